restoring_divider_8: RTL
========================

RESTORING_DIVIDER_8 -- requirements
Module: restoring_divider_8

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: load operands and begin a new division.
REQ-004 The module SHALL have port enable, input, 1 bit: iteration step strobe from the Control Unit.
REQ-005 The module SHALL have port dividend, input, 8 bits: numerator, sampled only on start.
REQ-006 The module SHALL have port divisor, input, 8 bits: denominator, sampled only on start.
REQ-007 The module SHALL have port quotient, output, 8 bits: registered Q register.
REQ-008 The module SHALL have port remainder, output, 8 bits: registered A register.
REQ-009 The module SHALL have port done, output, 1 bit: high after 8 completed iterations and held until the next start or rst.
REQ-010 The module SHALL have port busy, output, 1 bit: high from the start load until done.
REQ-011 The module SHALL have port div_by_zero, output, 1 bit: registered, set on start when divisor==0.

Function
REQ-012 Internal state SHALL be A[8:0] (partial remainder plus sign guard), Q[7:0], M[7:0] and a 4-bit iteration counter cnt.
REQ-013 On a clock edge with start=1, the block SHALL load A=0, Q=dividend, M=divisor and cnt=0, clear done, set busy=1, and set div_by_zero=(divisor==0).
REQ-014 start SHALL have priority over enable in the same cycle.
REQ-015 On a clock edge with start=0, enable=1 and busy=1, the block SHALL perform one iteration:
- shift {A,Q} left by 1;
- compute T = A - {1'b0,M} at 9-bit width;
- if T[8]=1, restore: A unchanged, Q[0]=0;
- otherwise A=T and Q[0]=1;
- cnt = cnt+1.
REQ-016 On the edge of the 8th iteration (cnt reaches 8), the block SHALL set done=1 and busy=0 in the same edge.
REQ-017 With enable=0, or when busy=0, all state SHALL hold; enable gaps only stretch latency and do not alter the result.
REQ-018 Minimum latency SHALL be 1 start edge plus 8 enabled edges; quotient and remainder SHALL be final on the same edge that done rises.
REQ-019 The outputs SHALL be driven as quotient=Q and remainder=A[7:0]; intermediate values are visible during operation and carry no meaning until done.
REQ-020 Divide-by-zero SHALL NOT be trapped and SHALL run the normal 8 iterations, yielding quotient=8'hFF and remainder=dividend with div_by_zero=1.
REQ-021 A start asserted while busy=1 SHALL abort the current operation and restart with the new operands.
REQ-022 enable pulses arriving after done SHALL be ignored; the outputs stay stable.

Reset
REQ-023 rst=1 SHALL asynchronously clear A, Q, M and cnt, and drive quotient=0, remainder=0, done=0, busy=0 and div_by_zero=0, including in the middle of an operation.
REQ-024 After rst is released, the block SHALL stay idle until start is asserted.

Configuration
REQ-025 With macro SIGNED_DIV_EN defined, dividend and divisor SHALL be two's complement:
- magnitudes are loaded on start;
- the 8 iterations run unsigned;
- on the done edge, quotient is negated if the operand signs differ, and remainder is negated if the dividend is negative;
- -128/-1 SHALL wrap to quotient=8'h80, remainder=0.
REQ-026 Without SIGNED_DIV_EN, the operation SHALL be unsigned only, with no sign logic synthesized.

Verification
REQ-027 The bench SHALL cover: dividend=100, divisor=7, start, then 8 consecutive enables -> done on the 8th enabled edge, quotient=14, remainder=2, div_by_zero=0.
REQ-028 The bench SHALL cover: dividend=5, divisor=9 -> quotient=0, remainder=5; and dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-029 The bench SHALL cover: dividend=8'h2A, divisor=0 -> div_by_zero=1 after the start edge, and after 8 enables quotient=8'hFF, remainder=8'h2A.
REQ-030 The bench SHALL cover: 100/7 with enable deasserted for 3 cycles after the 4th iteration -> done after the 8th enabled edge, result 14 R 2, and further enables leave the outputs unchanged.
REQ-031 The bench SHALL cover: rst pulsed after 5 iterations -> all outputs 0 immediately; a new start with 200/10 -> quotient=20, remainder=0.
REQ-032 With SIGNED_DIV_EN defined, the bench SHALL cover: -100/7 -> quotient=8'hF2 (-14), remainder=8'hFE (-2); and -128/-1 -> quotient=8'h80, remainder=0.

Source files
------------

// File: rtl/restoring_divider_8.sv
// restoring_divider_8: 8-bit restoring divider, one quotient bit per enabled clock.
// Optional macro SIGNED_DIV_EN: two's-complement operands via magnitude load and sign fix-up on done.
`default_nettype none

module restoring_divider_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       enable,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       done,
  output logic       busy,
  output logic       div_by_zero
);

  logic [8:0] a_reg;
  logic [7:0] q_reg;
  logic [7:0] m_reg;
  logic [3:0] cnt;

  logic [8:0] a_shift;
  logic [9:0] trial;
  logic [8:0] a_next;
  logic [7:0] q_next;
  logic [7:0] load_q;
  logic [7:0] load_m;

  // The guard bit a_reg[8] is always 0 between iterations, so the 10-bit trial
  // subtraction gives the same sign decision as the 9-bit one.
  assign a_shift = {a_reg[7:0], q_reg[7]};
  assign trial   = {a_reg[8], a_shift} - {2'b00, m_reg};
  assign a_next  = trial[9] ? a_shift : trial[8:0];
  assign q_next  = {q_reg[6:0], ~trial[9]};

`ifdef SIGNED_DIV_EN
  logic q_neg;
  logic r_neg;
  assign load_q = dividend[7] ? (8'd0 - dividend) : dividend;
  assign load_m = divisor[7]  ? (8'd0 - divisor)  : divisor;
`else
  assign load_q = dividend;
  assign load_m = divisor;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= 9'd0;
      q_reg       <= 8'd0;
      m_reg       <= 8'd0;
      cnt         <= 4'd0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else if (start) begin
      a_reg       <= 9'd0;
      q_reg       <= load_q;
      m_reg       <= load_m;
      cnt         <= 4'd0;
      done        <= 1'b0;
      busy        <= 1'b1;
      div_by_zero <= (divisor == 8'd0);
`ifdef SIGNED_DIV_EN
      q_neg       <= dividend[7] ^ divisor[7];
      r_neg       <= dividend[7];
`endif
    end else if (enable && busy) begin
      cnt <= cnt + 4'd1;
      if (cnt == 4'd7) begin
        done <= 1'b1;
        busy <= 1'b0;
`ifdef SIGNED_DIV_EN
        q_reg <= q_neg ? (8'd0 - q_next) : q_next;
        a_reg <= r_neg ? {1'b0, 8'd0 - a_next[7:0]} : a_next;
`else
        q_reg <= q_next;
        a_reg <= a_next;
`endif
      end else begin
        q_reg <= q_next;
        a_reg <= a_next;
      end
    end
  end

  assign quotient  = q_reg;
  assign remainder = a_reg[7:0];

endmodule

`default_nettype wire
